// File: rtl/boolean_coefficient_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : boolean_coefficient_loader                                     |
// | Purpose  : Host-side writer for the solver's boolean coefficient bus.     |
// |            Coefficient words arrive over a valid/ready stream and are     |
// |            assembled into a shadow register. The complete                 |
// |            2*NUM_BOOL_VARS-bit vector is then committed in a single       |
// |            cycle, so the solver never sees a partially loaded set.        |
// | Ports    : clk, reset (sync, active-high)                                 |
// |            in_start  - 1-cycle pulse, begins a new load (any state)       |
// |            in_data / in_valid / out_ready - word stream handshake         |
// |            out_boolean_coefficients - committed set, to the solver        |
// |            out_coefficients_valid   - committed set is complete/current   |
// |            out_busy      - high while loading or committing               |
// |            out_load_done - 1-cycle pulse after the commit edge            |
// | Options  : COEFF_PARITY_EN - adds in_parity (even parity over in_data)   |
// |            and sticky out_parity_error; a bad word aborts the load.      |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+

`ifndef NUMBER_OF_BOOLEAN_VARIABLES
`define NUMBER_OF_BOOLEAN_VARIABLES 8
`endif

module boolean_coefficient_loader #(
  parameter int NUM_BOOL_VARS = `NUMBER_OF_BOOLEAN_VARIABLES,
  parameter int WORD_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_start,
  input  logic [WORD_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
`ifdef COEFF_PARITY_EN
  input  logic                       in_parity,
  output logic                       out_parity_error,
`endif
  output logic                       out_ready,
  output logic [2*NUM_BOOL_VARS-1:0] out_boolean_coefficients,
  output logic                       out_coefficients_valid,
  output logic                       out_busy,
  output logic                       out_load_done
);

  localparam int TOTAL = 2 * NUM_BOOL_VARS;
  localparam int WORDS = (TOTAL + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] coeff_q, coeff_d;
  logic             cvalid_q, cvalid_d;
  logic             done_q, done_d;

  logic w_accept;
  logic w_par_bad;

  assign w_accept = in_valid && (state_q == S_LOAD);

`ifdef COEFF_PARITY_EN
  logic perr_q, perr_d;
  // Even parity: the parity bit equals the XOR of the data bits.
  assign w_par_bad        = (in_parity != ^in_data);
  assign out_parity_error = perr_q;
`else
  assign w_par_bad = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (in_start) begin
      // Restart wins over everything, including a word presented this cycle.
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_LOAD: begin
          if (w_accept) begin
            if (w_par_bad) begin
              state_d = S_IDLE;
            end else if (cnt_q == LAST_IDX) begin
              state_d = S_COMMIT;
            end
          end
        end
        S_COMMIT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ state outputs
  always_comb begin
    out_ready = (state_q == S_LOAD);
    out_busy  = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------- datapath next
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    cvalid_d = cvalid_q;
    done_d   = 1'b0;
`ifdef COEFF_PARITY_EN
    perr_d   = perr_q;
`endif
    if (in_start) begin
      cnt_d    = '0;
      shadow_d = '0;
      cvalid_d = 1'b0;
`ifdef COEFF_PARITY_EN
      perr_d   = 1'b0;
`endif
    end else if (w_accept) begin
      if (w_par_bad) begin
`ifdef COEFF_PARITY_EN
        perr_d = 1'b1;
`endif
        cnt_d  = '0;
      end else begin
        // Bit b of the vector lives in word b/WORD_WIDTH; bits of the last
        // word that fall beyond TOTAL-1 simply have no destination.
        for (int b = 0; b < TOTAL; b++) begin
          if (cnt_q == CNT_W'(b / WORD_WIDTH)) begin
            shadow_d[b] = in_data[b % WORD_WIDTH];
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == S_COMMIT) begin
      coeff_d  = shadow_q;
      cvalid_d = 1'b1;
      done_d   = 1'b1;
    end
  end

  // ---------------------------------------------------------- datapath regs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      coeff_q  <= '0;
      cvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef COEFF_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      cvalid_q <= cvalid_d;
      done_q   <= done_d;
`ifdef COEFF_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign out_boolean_coefficients = coeff_q;
  assign out_coefficients_valid   = cvalid_q;
  assign out_load_done            = done_q;

endmodule

`default_nettype wire
